fpu_dispatch: RTL and testbench

FPU_DISPATCH -- requirements
Module: fpu_dispatch

---
 rtl/fpu_pkg.sv | 50 +++++
 rtl/fpu_sync_fifo.sv | 47 ++++
 rtl/fpu_dispatch.sv | 255 +++++++++++++++++++++++++
 tb/tb_fpu_dispatch.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU dispatch block: unit selects, FSM
// states, exception-flag bit positions, the canonical NaN and the result entry.
package fpu_pkg;

  typedef enum logic [3:0] {
    UNIT_FCLASS = 4'd0,
    UNIT_SINJ   = 4'd1,
    UNIT_CMP    = 4'd2,
    UNIT_MINMAX = 4'd3,
    UNIT_I2F    = 4'd4,
    UNIT_F2I    = 4'd5,
    UNIT_ADDSUB = 4'd6,
    UNIT_MUL    = 4'd7,
    UNIT_FMA    = 4'd8,
    UNIT_DIV    = 4'd9,
    UNIT_SQRT   = 4'd10
  } fpu_unit_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PUSH  = 2'd3
  } disp_state_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Tag width is a module parameter, so the tag travels next to this struct
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  flags;
    logic        illegal;
    logic        timeout;
  } res_entry_t;

  // Unknown units, and the sign-inject / compare units with the reserved mode,
  // never reach the execution side
  function automatic logic cmd_is_illegal(input logic [3:0] unit, input logic [1:0] mode);
    return (unit > 4'(UNIT_SQRT)) ||
           (((unit == 4'(UNIT_SINJ)) || (unit == 4'(UNIT_CMP))) && (mode == 2'b11));
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pointers carry one extra bit so
// full and empty are told apart without a separate counter.
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpu_dispatch.sv
// FPU command dispatcher: queues commands, issues them one at a time to the
// execution side, collects responses into a result queue and accrues flags.
// Optional macro FPU_DISPATCH_TIMEOUT_EN adds a response watchdog that returns
// a canonical NaN with NV after TIMEOUT cycles in WAIT.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_unit,
  input  logic [1:0]       cmd_mode,
  input  logic [2:0]       cmd_frm,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [31:0]      cmd_c,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             ex_req_valid,
  input  logic             ex_req_ready,
  output logic [3:0]       ex_req_unit,
  output logic [1:0]       ex_req_mode,
  output logic [2:0]       ex_req_frm,
  output logic [31:0]      ex_req_a,
  output logic [31:0]      ex_req_b,
  output logic [31:0]      ex_req_c,
  input  logic             ex_rsp_valid,
  input  logic [31:0]      ex_rsp_data,
  input  logic [4:0]       ex_rsp_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [4:0]       res_flags,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_illegal,
  output logic             res_timeout,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy
);

  localparam int CMD_W = TAG_W + 4 + 2 + 3 + 96;
  localparam int RES_W = TAG_W + $bits(res_entry_t);
  localparam logic [4:0] NV_MASK = 5'b1 << FLAG_NV;

  // Elaboration-time parameter sanity
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
    $error("CMD_DEPTH must be a power of two >= 2");
  end
  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_res_depth
    $error("RES_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  disp_state_e state_q, state_d;

  logic [CMD_W-1:0] cmd_rdata;
  logic             cmd_full, cmd_empty, cmd_pop;
  logic [TAG_W-1:0] h_tag;
  logic [3:0]       h_unit;
  logic [1:0]       h_mode;
  logic [2:0]       h_frm;
  logic [31:0]      h_a, h_b, h_c;
  logic             h_illegal;

  logic [RES_W-1:0] res_wdata, res_rdata;
  logic             res_full, res_empty, res_push;
  res_entry_t       res_head;

  logic [TAG_W-1:0] cur_tag_q;
  logic [3:0]       cur_unit_q;
  logic [1:0]       cur_mode_q;
  logic [2:0]       cur_frm_q;
  logic [31:0]      cur_a_q, cur_b_q, cur_c_q;
  logic [31:0]      out_data_q;
  logic [4:0]       out_flags_q;
  logic             out_illegal_q;
  logic             out_timeout;

  logic [4:0]       fflags_q, fflags_d, ff_set;

  assign cmd_ready = !cmd_full && !rst;

  fpu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_tag, cmd_unit, cmd_mode, cmd_frm, cmd_a, cmd_b, cmd_c}),
    .pop   (cmd_pop),
    .rdata (cmd_rdata),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  assign {h_tag, h_unit, h_mode, h_frm, h_a, h_b, h_c} = cmd_rdata;
  assign h_illegal = cmd_is_illegal(h_unit, h_mode);

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;
  logic             timeout_q;

  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
  assign tmo_cnt_d = (state_q == ST_WAIT && !ex_rsp_valid) ? tmo_cnt_q + 1'b1 : '0;
  assign out_timeout = timeout_q;

  // Watchdog counts consecutive WAIT cycles without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (cmd_pop) timeout_q <= 1'b0;
      else if (state_q == ST_WAIT && !ex_rsp_valid && tmo_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign out_timeout = 1'b0;
`endif

  // Next-state and handshake strobes for the one-command-at-a-time sequencer
  always_comb begin
    state_d      = state_q;
    cmd_pop      = 1'b0;
    res_push     = 1'b0;
    ex_req_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only start when the result slot is guaranteed, so PUSH never stalls
        if (!cmd_empty && !res_full) begin
          cmd_pop = 1'b1;
          state_d = h_illegal ? ST_PUSH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ex_req_valid = 1'b1;
        if (ex_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ex_rsp_valid) state_d = ST_PUSH;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        else if (tmo_hit) state_d = ST_PUSH;
`endif
      end
      ST_PUSH: begin
        res_push = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Capture the popped command and then the response (or watchdog result)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_tag_q     <= '0;
      cur_unit_q    <= '0;
      cur_mode_q    <= '0;
      cur_frm_q     <= '0;
      cur_a_q       <= '0;
      cur_b_q       <= '0;
      cur_c_q       <= '0;
      out_data_q    <= '0;
      out_flags_q   <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      if (cmd_pop) begin
        cur_tag_q     <= h_tag;
        cur_unit_q    <= h_unit;
        cur_mode_q    <= h_mode;
        cur_frm_q     <= h_frm;
        cur_a_q       <= h_a;
        cur_b_q       <= h_b;
        cur_c_q       <= h_c;
        out_data_q    <= '0;
        out_flags_q   <= '0;
        out_illegal_q <= h_illegal;
      end
      if (state_q == ST_WAIT) begin
        if (ex_rsp_valid) begin
          out_data_q  <= ex_rsp_data;
          out_flags_q <= ex_rsp_flags;
        end
`ifdef FPU_DISPATCH_TIMEOUT_EN
        else if (tmo_hit) begin
          out_data_q  <= CANON_NAN;
          out_flags_q <= NV_MASK;
        end
`endif
      end
    end
  end

  assign ex_req_unit = cur_unit_q;
  assign ex_req_mode = cur_mode_q;
  assign ex_req_frm  = cur_frm_q;
  assign ex_req_a    = cur_a_q;
  assign ex_req_b    = cur_b_q;
  assign ex_req_c    = cur_c_q;

  assign res_wdata = {cur_tag_q, res_entry_t'{data: out_data_q, flags: out_flags_q,
                                              illegal: out_illegal_q, timeout: out_timeout}};

  fpu_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .wdata (res_wdata),
    .pop   (res_ready),
    .rdata (res_rdata),
    .full  (res_full),
    .empty (res_empty)
  );

  assign {res_tag, res_head} = res_rdata;
  assign res_valid   = !res_empty;
  assign res_data    = res_head.data;
  assign res_flags   = res_head.flags;
  assign res_illegal = res_head.illegal;
  assign res_timeout = res_head.timeout;

  // Sticky flag accrual; a clear in the push cycle keeps only the new flags
  always_comb begin
    ff_set = '0;
    if (res_push) ff_set = out_flags_q | (out_illegal_q ? NV_MASK : 5'b0);
    fflags_d = fflags_clr ? ff_set : (fflags_q | ff_set);
  end

  // Accrued flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fflags_q <= '0;
    else     fflags_q <= fflags_d;
  end

  assign fflags = fflags_q;
  assign busy   = (state_q != ST_IDLE) || !cmd_empty;

endmodule

// File: tb/tb_fpu_dispatch.sv
`timescale 1ns/1ps
module tb_fpu_dispatch;
  import fpu_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_unit;
  logic [1:0]       cmd_mode;
  logic [2:0]       cmd_frm;
  logic [31:0]      cmd_a, cmd_b, cmd_c;
  logic [TAG_W-1:0] cmd_tag;
  logic             ex_req_valid, ex_req_ready;
  logic [3:0]       ex_req_unit;
  logic [1:0]       ex_req_mode;
  logic [2:0]       ex_req_frm;
  logic [31:0]      ex_req_a, ex_req_b, ex_req_c;
  logic             ex_rsp_valid;
  logic [31:0]      ex_rsp_data;
  logic [4:0]       ex_rsp_flags;
  logic             res_valid, res_ready;
  logic [31:0]      res_data;
  logic [4:0]       res_flags;
  logic [TAG_W-1:0] res_tag;
  logic             res_illegal, res_timeout;
  logic [4:0]       fflags;
  logic             fflags_clr, busy;

  always #5 clk = ~clk;

  fpu_dispatch #(.CMD_DEPTH(4), .RES_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit), .cmd_mode(cmd_mode),
    .cmd_frm(cmd_frm), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_tag(cmd_tag),
    .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready), .ex_req_unit(ex_req_unit),
    .ex_req_mode(ex_req_mode), .ex_req_frm(ex_req_frm), .ex_req_a(ex_req_a),
    .ex_req_b(ex_req_b), .ex_req_c(ex_req_c),
    .ex_rsp_valid(ex_rsp_valid), .ex_rsp_data(ex_rsp_data), .ex_rsp_flags(ex_rsp_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .res_tag(res_tag), .res_illegal(res_illegal), .res_timeout(res_timeout),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  typedef struct {
    logic [31:0]      data;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             timeout;
  } exp_t;

  typedef struct {
    logic [3:0]  unit;
    logic [1:0]  mode;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp_data;
    logic [4:0]  exp_flags;
    logic        exp_ill;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Control knobs for the execution stub and the result sink
  logic ready_en   = 1'b1;
  logic rsp_en     = 1'b1;
  logic res_rdy_en = 1'b1;
  logic late_rsp   = 1'b0;
  logic saw_req    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Execution stub: returns operand c as data and b[4:0] as flags one cycle
  // after the request handshake
  initial begin : responder
    logic        pend;
    logic [31:0] pd;
    logic [4:0]  pf;
    pend = 1'b0; pd = '0; pf = '0;
    ex_req_ready = 1'b0; ex_rsp_valid = 1'b0; ex_rsp_data = '0; ex_rsp_flags = '0;
    forever begin
      @(negedge clk);
      ex_rsp_valid = 1'b0;
      if (late_rsp) begin
        ex_rsp_valid = 1'b1; ex_rsp_data = 32'hDEAD_BEEF; ex_rsp_flags = 5'h1F;
        late_rsp = 1'b0;
      end else if (pend && rsp_en) begin
        ex_rsp_valid = 1'b1; ex_rsp_data = pd; ex_rsp_flags = pf;
      end
      ex_req_ready = ready_en;
      pend = ex_req_valid && ex_req_ready && !rst;
      if (ex_req_valid) saw_req = 1'b1;
      pd = ex_req_c;
      pf = ex_req_b[4:0];
    end
  end

  // Result sink and scoreboard comparison
  initial begin : monitor
    exp_t e;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      res_ready = res_rdy_en;
      if (res_valid && res_ready && !rst) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] result tag=%0d data=%08h flags=%05b ill=%0b tmo=%0b",
                   res_tag, res_data, res_flags, res_illegal, res_timeout);
          check("res_tag", res_tag, e.tag);
          check("res_data", res_data, e.data);
          check("res_flags", res_flags, e.flags);
          check("res_illegal", res_illegal, e.illegal);
          check("res_timeout", res_timeout, e.timeout);
        end
      end
    end
  end

  // Drive one command starting at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [3:0] unit, input logic [1:0] mode, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic [TAG_W-1:0] tag,
                      input logic expect_res, input exp_t e);
    int n = 0;
    cmd_valid = 1'b1; cmd_unit = unit; cmd_mode = mode; cmd_frm = tag[2:0];
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_tag = tag;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_wait", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (expect_res) sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy || res_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", sb_q.size(), 0);
    check("drain_not_busy", busy, 0);
  endtask

  task automatic clear_flags();
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    vec_t vecs[10];
    exp_t e;
    logic [4:0] exp_ff;
    int lat;
    logic got_res;

    vecs[0] = '{4'd6,  2'd0, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 5'b00000, 1'b0};
    vecs[1] = '{4'd0,  2'd0, 32'h0000_0001, 32'h0000_0200, 32'h0000_0200, 5'b00001, 1'b0};
    vecs[2] = '{4'd1,  2'd2, 32'h0000_0000, 32'hBF80_0000, 32'hBF80_0000, 5'b00000, 1'b0};
    vecs[3] = '{4'd1,  2'd3, 32'h0000_0004, 32'h1111_1111, 32'h0000_0000, 5'b00000, 1'b1};
    vecs[4] = '{4'd2,  2'd3, 32'h0000_0002, 32'h2222_2222, 32'h0000_0000, 5'b00000, 1'b1};
    vecs[5] = '{4'd11, 2'd0, 32'h0000_0001, 32'h3333_3333, 32'h0000_0000, 5'b00000, 1'b1};
    vecs[6] = '{4'd15, 2'd1, 32'h0000_0008, 32'h4444_4444, 32'h0000_0000, 5'b00000, 1'b1};
    vecs[7] = '{4'd10, 2'd0, 32'h0000_0010, 32'h7FC0_0000, 32'h7FC0_0000, 5'b10000, 1'b0};
    vecs[8] = '{4'd3,  2'd3, 32'h0000_0003, 32'h3F00_0000, 32'h3F00_0000, 5'b00011, 1'b0};
    vecs[9] = '{4'd7,  2'd1, 32'h0000_0000 | (32'd1 << FLAG_DZ), 32'h4110_0000, 32'h4110_0000,
                5'b01000, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_unit = '0; cmd_mode = '0; cmd_frm = '0;
    cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_tag = '0; fflags_clr = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ex_req_valid", ex_req_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fflags", fflags, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);

    // Single add with minimum latency
    e = '{32'h4040_0000, 5'b0, 4'd5, 1'b0, 1'b0};
    send(UNIT_ADDSUB, 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 4'd5, 1'b1, e);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("add_req_valid", ex_req_valid, 1);
        check("add_req_unit", ex_req_unit, 4'd6);
        check("add_req_a", ex_req_a, 32'h3F80_0000);
        check("add_req_b", ex_req_b, 32'h4000_0000);
        check("add_req_frm", ex_req_frm, 3'd5);
      end
    end
    check("add_latency", lat, 4);
    check("add_res_data", res_data, 32'h4040_0000);
    wait_drain();

    // Illegal command never reaches the execution side
    clear_flags();
    saw_req = 1'b0;
    e = '{32'h0, 5'b0, 4'd9, 1'b1, 1'b0};
    send(UNIT_CMP, 2'b11, 32'h1, 32'h2, 32'h3, 4'd9, 1'b1, e);
    wait_drain();
    check("illegal_no_req", saw_req, 0);
    check("illegal_fflags_nv", fflags[FLAG_NV], 1);

    // Table of mixed legal and illegal commands
    clear_flags();
    exp_ff = '0;
    for (int i = 0; i < 10; i++) begin
      e = '{vecs[i].exp_data, vecs[i].exp_flags, TAG_W'(i), vecs[i].exp_ill, 1'b0};
      exp_ff |= vecs[i].exp_ill ? (5'b1 << FLAG_NV) : vecs[i].exp_flags;
      send(vecs[i].unit, vecs[i].mode, 32'h1234_0000 + i, vecs[i].b, vecs[i].c, TAG_W'(i), 1'b1, e);
    end
    wait_drain();
    check("table_fflags", fflags, exp_ff);

    // Backpressure on both the execution request and the result sink
    ready_en = 1'b0; res_rdy_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = '{32'hA000_0000 + i, 5'b0, TAG_W'(i), 1'b0, 1'b0};
      send(UNIT_MUL, 2'd0, 32'h0, 32'h0, 32'hA000_0000 + i, TAG_W'(i), 1'b1, e);
    end
    check("bp_cmd_full", cmd_ready, 0);
    check("bp_req_held", ex_req_valid, 1);
    check("bp_req_c_stable", ex_req_c, 32'hA000_0000);
    ready_en = 1'b1;
    repeat (30) @(negedge clk);
    check("bp_res_held", res_valid, 1);
    check("bp_res_head_tag", res_tag, 4'd0);
    check("bp_busy", busy, 1);
    res_rdy_en = 1'b1;
    wait_drain();

    // Sticky flag accrual and clear colliding with a push
    clear_flags();
    e = '{32'h1, 5'b1 << FLAG_NX, 4'd1, 1'b0, 1'b0};
    send(UNIT_ADDSUB, 2'd0, 32'h0, 32'h1 << FLAG_NX, 32'h1, 4'd1, 1'b1, e);
    wait_drain();
    e = '{32'h2, 5'b1 << FLAG_OF, 4'd2, 1'b0, 1'b0};
    send(UNIT_MUL, 2'd0, 32'h0, 32'h1 << FLAG_OF, 32'h2, 4'd2, 1'b1, e);
    wait_drain();
    check("sticky_nx_of", fflags, 5'b00101);
    e = '{32'h3, 5'b1 << FLAG_UF, 4'd3, 1'b0, 1'b0};
    send(UNIT_FMA, 2'd0, 32'h0, 32'h1 << FLAG_UF, 32'h3, 4'd3, 1'b1, e);
    repeat (3) @(negedge clk);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    check("sticky_clr_with_uf", fflags, 5'b00010);
    wait_drain();

    // No response from the execution side
    rsp_en = 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    e = '{CANON_NAN, 5'b1 << FLAG_NV, 4'd7, 1'b0, 1'b1};
    send(UNIT_DIV, 2'd0, 32'h3F80_0000, 32'h0, 32'h0, 4'd7, 1'b1, e);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency", lat, 11);
    check("timeout_flag", res_timeout, 1);
    check("timeout_data", res_data, CANON_NAN);
    wait_drain();
`else
    e = '{32'h0, 5'b0, 4'd7, 1'b0, 1'b0};
    send(UNIT_DIV, 2'd0, 32'h3F80_0000, 32'h0, 32'h0, 4'd7, 1'b0, e);
    repeat (20) @(negedge clk);
    check("no_timeout_busy", busy, 1);
    check("no_timeout_no_res", res_valid, 0);
`endif

    // Reset while waiting on a response, then a stale response
    e = '{32'h0, 5'b0, 4'd0, 1'b0, 1'b0};
    send(UNIT_DIV, 2'd0, 32'h0, 32'h0, 32'h5, 4'd10, 1'b0, e);
    send(UNIT_SQRT, 2'd0, 32'h0, 32'h0, 32'h6, 4'd11, 1'b0, e);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_ex_req_valid", ex_req_valid, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fflags", fflags, 0);
    @(negedge clk);
    rst = 1'b0;
    late_rsp = 1'b1;
    got_res = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) got_res = 1'b1;
    end
    check("late_rsp_ignored", got_res, 0);
    check("late_rsp_idle", busy, 0);
    check("late_rsp_cmd_ready", cmd_ready, 1);

    // Normal operation resumes after reset
    rsp_en = 1'b1;
    e = '{32'hCAFE_0001, 5'b0, 4'd12, 1'b0, 1'b0};
    send(UNIT_I2F, 2'd0, 32'h0, 32'h0, 32'hCAFE_0001, 4'd12, 1'b1, e);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
